// File: rtl/rr_priority_encoder_if.sv
// Request/grant bundle for rr_priority_encoder: request side, result side and block enable.
interface rr_priority_encoder_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned IdxW = $clog2(WIDTH);

  logic             enable;
  logic [WIDTH-1:0] in;
  logic             in_valid;
  logic             in_ready;
  logic [IdxW-1:0]  out;
  logic [WIDTH-1:0] out_onehot;
  logic             out_valid;
  logic             out_ready;
  logic             multi;
  logic             zero_drop;

  // Driver of requests and consumer of results.
  modport master (
    output enable, in, in_valid, out_ready,
    input  in_ready, out, out_onehot, out_valid, multi, zero_drop
  );

  // The encoder itself.
  modport slave (
    input  enable, in, in_valid, out_ready,
    output in_ready, out, out_onehot, out_valid, multi, zero_drop
  );
endinterface

// File: rtl/rr_priority_encoder.sv
// Registered priority encoder: picks one set bit of an arbitrary request vector by fixed
// (lowest index) or round-robin priority and returns it as index + one-hot behind a
// single valid/ready output stage.
module rr_priority_encoder #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned RR_MODE = 0
) (
  input logic                  clk,
  input logic                  reset,
  rr_priority_encoder_if.slave bus
);
  localparam int unsigned IdxW = $clog2(WIDTH);

  logic [IdxW-1:0]  r_out;
  logic [WIDTH-1:0] r_onehot;
  logic             r_out_valid;
  logic             r_multi;
  logic             r_zero_drop;
  logic [IdxW-1:0]  r_ptr;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_nonzero;
  logic             w_multi;
  logic [IdxW-1:0]  w_fixed_idx;
  logic [IdxW-1:0]  w_rr_idx;
  logic             w_rr_found;
  logic [IdxW-1:0]  w_win_idx;
  logic [WIDTH-1:0] w_win_onehot;
  logic [IdxW-1:0]  w_next_ptr;
  int unsigned      v_pos;

  // Ready never looks at in_valid, so upstream may wait for it before asserting valid.
  assign w_in_ready = bus.enable & (~r_out_valid | bus.out_ready);
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_nonzero  = |bus.in;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign w_multi    = |(bus.in & (bus.in - WIDTH'(1)));

  // Fixed priority: scan downward so the lowest set index is the last one written.
  always_comb begin
    w_fixed_idx = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (((bus.in >> i) & WIDTH'(1)) != '0) begin
        w_fixed_idx = IdxW'(i);
      end
    end
  end

  // Round-robin: first set bit at or above ptr, wrapping at WIDTH-1 (not at 2^IdxW-1).
  always_comb begin
    w_rr_idx   = '0;
    w_rr_found = 1'b0;
    v_pos      = 0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      v_pos = 32'(r_ptr) + k;
      if (v_pos >= WIDTH) begin
        v_pos = v_pos - WIDTH;
      end
      if (!w_rr_found && (((bus.in >> v_pos) & WIDTH'(1)) != '0)) begin
        w_rr_found = 1'b1;
        w_rr_idx   = IdxW'(v_pos);
      end
    end
  end

  // Winner select and pointer successor (winner + 1 mod WIDTH).
  always_comb begin
    w_win_idx    = (RR_MODE != 0) ? w_rr_idx : w_fixed_idx;
    w_win_onehot = WIDTH'(1) << w_win_idx;
    if (w_win_idx == IdxW'(WIDTH - 1)) begin
      w_next_ptr = '0;
    end else begin
      w_next_ptr = w_win_idx + IdxW'(1);
    end
  end

  // Output stage, zero-drop pulse and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out       <= '0;
      r_onehot    <= '0;
      r_out_valid <= 1'b0;
      r_multi     <= 1'b0;
      r_zero_drop <= 1'b0;
      r_ptr       <= '0;
    end else begin
      r_zero_drop <= w_accept & ~w_nonzero;
      if (w_accept && w_nonzero) begin
        r_out       <= w_win_idx;
        r_onehot    <= w_win_onehot;
        r_multi     <= w_multi;
        r_out_valid <= 1'b1;
        if (RR_MODE != 0) begin
          r_ptr <= w_next_ptr;
        end
      end else if (r_out_valid && bus.out_ready) begin
        // Covers a plain drain and a zero vector accepted in the same cycle.
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out        = r_out;
  assign bus.out_onehot = r_onehot;
  assign bus.out_valid  = r_out_valid;
  assign bus.multi      = r_multi;
  assign bus.zero_drop  = r_zero_drop;
endmodule

// File: tb/tb_rr_priority_encoder.sv
// Self-checking bench for rr_priority_encoder: fixed-priority, round-robin and WIDTH=5
// instances, with a scoreboard of expected results filled as requests are driven.
module tb_rr_priority_encoder;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  rr_priority_encoder_if #(.WIDTH(8)) if_fix ();
  rr_priority_encoder_if #(.WIDTH(8)) if_rr ();
  rr_priority_encoder_if #(.WIDTH(5)) if_w5 ();

  rr_priority_encoder #(.WIDTH(8), .RR_MODE(0)) u_fix (.clk(clk), .reset(reset), .bus(if_fix));
  rr_priority_encoder #(.WIDTH(8), .RR_MODE(1)) u_rr  (.clk(clk), .reset(reset), .bus(if_rr));
  rr_priority_encoder #(.WIDTH(5), .RR_MODE(1)) u_w5  (.clk(clk), .reset(reset), .bus(if_w5));

  typedef struct {
    int         idx;
    logic [7:0] oh;
    logic       multi;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ptr_rr  = 0;
  int   ptr_w5  = 0;

  // Reference model: winner of vector v (w bits), fixed or round-robin from p.
  function automatic int model_win(input logic [7:0] v, input int w, input int rr, input int p);
    for (int k = 0; k < w; k++) begin
      int pos = (rr != 0) ? (p + k) % w : k;
      if (((v >> pos) & 8'h01) != 8'h00) return pos;
    end
    return 0;
  endfunction

  // Queue the expected result for an accepted nonzero vector and advance the model pointer.
  function automatic void push_exp(input logic [7:0] v, input int w, input int rr,
                                   input int p_in, output int p_out);
    exp_t x;
    x.idx   = model_win(v, w, rr, p_in);
    x.oh    = 8'h01 << x.idx;
    x.multi = ($countones(v) >= 2);
    exp_q.push_back(x);
    p_out = (rr != 0) ? (x.idx + 1) % w : 0;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    if_fix.enable = 1'b0; if_fix.in = '0; if_fix.in_valid = 1'b0; if_fix.out_ready = 1'b0;
    if_rr.enable  = 1'b0; if_rr.in  = '0; if_rr.in_valid  = 1'b0; if_rr.out_ready  = 1'b0;
    if_w5.enable  = 1'b0; if_w5.in  = '0; if_w5.in_valid  = 1'b0; if_w5.out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    ptr_rr = 0;
    ptr_w5 = 0;
  endtask

  task automatic test_reset();
    int dummy;
    do_reset();
    if_fix.enable = 1'b1; if_fix.in = 8'b0010_0000; if_fix.in_valid = 1'b1;
    push_exp(8'b0010_0000, 8, 0, 0, dummy);
    @(negedge clk);
    if_fix.in_valid = 1'b0;
    @(negedge clk);
    e = exp_q[0];
    n_tests++;
    if (if_fix.out_valid !== 1'b1 || int'(if_fix.out) !== e.idx) begin
      n_fail++;
      $display("FAIL reset_prehold: valid=%0b out=%0d want valid=1 out=%0d",
               if_fix.out_valid, if_fix.out, e.idx);
    end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({if_fix.out_valid, if_fix.out, if_fix.out_onehot, if_fix.multi, if_fix.zero_drop} !== '0)
    begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%0b out=%0d oh=%b multi=%0b zd=%0b want all 0",
               if_fix.out_valid, if_fix.out, if_fix.out_onehot, if_fix.multi, if_fix.zero_drop);
    end
    n_tests++;
    if (u_rr.r_ptr !== 3'd0 || u_w5.r_ptr !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_ptr: rr=%0d w5=%0d want 0", u_rr.r_ptr, u_w5.r_ptr);
    end
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_enable();
    int dummy;
    do_reset();
    if_fix.enable = 1'b0; if_fix.in = 8'b1000_0000; if_fix.in_valid = 1'b1;
    if_fix.out_ready = 1'b1;
    #1;
    n_tests++;
    if (if_fix.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_low_ready: got %0b want 0", if_fix.in_ready);
    end
    @(negedge clk);
    n_tests++;
    if (if_fix.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_low_valid: got %0b want 0", if_fix.out_valid);
    end
    if_fix.enable = 1'b1;
    push_exp(8'b1000_0000, 8, 0, 0, dummy);
    #1;
    n_tests++;
    if (if_fix.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL enable_high_ready: got %0b want 1", if_fix.in_ready);
    end
    @(negedge clk);
    if_fix.in_valid = 1'b0;
    e = exp_q.pop_front();
    n_tests++;
    if (if_fix.out_valid !== 1'b1 || int'(if_fix.out) !== e.idx || if_fix.out_onehot !== e.oh
        || if_fix.multi !== e.multi) begin
      n_fail++;
      $display("FAIL enable_result: valid=%0b out=%0d oh=%b multi=%0b want 1 %0d %b %0b",
               if_fix.out_valid, if_fix.out, if_fix.out_onehot, if_fix.multi,
               e.idx, e.oh, e.multi);
    end
    @(negedge clk);
    n_tests++;
    if (if_fix.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_drain: valid=%0b want 0", if_fix.out_valid);
    end
  endtask

  task automatic test_fixed();
    int dummy;
    do_reset();
    if_fix.enable = 1'b1; if_fix.out_ready = 1'b1;
    if_fix.in = 8'b1010_0100; if_fix.in_valid = 1'b1;
    push_exp(8'b1010_0100, 8, 0, 0, dummy);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) if_fix.in_valid = 1'b0;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL fixed_queue: got empty want entry");
      end else begin
        e = exp_q.pop_front();
        if (if_fix.out_valid !== 1'b1 || int'(if_fix.out) !== e.idx
            || if_fix.out_onehot !== e.oh || if_fix.multi !== e.multi) begin
          n_fail++;
          $display("FAIL fixed_%0d: valid=%0b out=%0d oh=%b multi=%0b want 1 %0d %b %0b", i,
                   if_fix.out_valid, if_fix.out, if_fix.out_onehot, if_fix.multi,
                   e.idx, e.oh, e.multi);
        end
      end
      if (i < 2) begin
        #1;
        n_tests++;
        if (if_fix.in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL fixed_b2b_ready_%0d: got %0b want 1", i, if_fix.in_ready);
        end
        push_exp(8'b1010_0100, 8, 0, 0, dummy);
      end
    end
    n_tests++;
    if (u_fix.r_ptr !== 3'd0) begin
      n_fail++;
      $display("FAIL fixed_ptr: got %0d want 0", u_fix.r_ptr);
    end
    @(negedge clk);
    n_tests++;
    if (if_fix.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fixed_drain: valid=%0b want 0", if_fix.out_valid);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    if_rr.enable = 1'b1; if_rr.out_ready = 1'b1;
    if_rr.in = 8'b1010_0100; if_rr.in_valid = 1'b1;
    push_exp(8'b1010_0100, 8, 1, ptr_rr, ptr_rr);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) if_rr.in_valid = 1'b0;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rr_queue: got empty want entry");
      end else begin
        e = exp_q.pop_front();
        if (if_rr.out_valid !== 1'b1 || int'(if_rr.out) !== e.idx
            || if_rr.out_onehot !== e.oh || if_rr.multi !== e.multi) begin
          n_fail++;
          $display("FAIL rr_%0d: valid=%0b out=%0d oh=%b multi=%0b want 1 %0d %b %0b", i,
                   if_rr.out_valid, if_rr.out, if_rr.out_onehot, if_rr.multi,
                   e.idx, e.oh, e.multi);
        end
      end
      n_tests++;
      if (int'(u_rr.r_ptr) !== ptr_rr) begin
        n_fail++;
        $display("FAIL rr_ptr_%0d: got %0d want %0d", i, u_rr.r_ptr, ptr_rr);
      end
      if (i < 3) push_exp(8'b1010_0100, 8, 1, ptr_rr, ptr_rr);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    do_reset();
    if_rr.enable = 1'b1; if_rr.out_ready = 1'b0;
    if_rr.in = 8'b1010_0100; if_rr.in_valid = 1'b1;
    push_exp(8'b1010_0100, 8, 1, ptr_rr, ptr_rr);
    @(negedge clk);
    if_rr.in = 8'b0000_0001;
    e = exp_q[0];
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (if_rr.in_ready !== 1'b0 || if_rr.out_valid !== 1'b1 || int'(if_rr.out) !== e.idx
          || if_rr.out_onehot !== e.oh || int'(u_rr.r_ptr) !== ptr_rr) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: rdy=%0b valid=%0b out=%0d oh=%b ptr=%0d want 0 1 %0d %b %0d",
                 i, if_rr.in_ready, if_rr.out_valid, if_rr.out, if_rr.out_onehot, u_rr.r_ptr,
                 e.idx, e.oh, ptr_rr);
      end
      @(negedge clk);
    end
    if_rr.out_ready = 1'b1;
    #1;
    n_tests++;
    if (if_rr.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %0b want 1", if_rr.in_ready);
    end
    void'(exp_q.pop_front());
    push_exp(8'b0000_0001, 8, 1, ptr_rr, ptr_rr);
    @(negedge clk);
    if_rr.in_valid = 1'b0;
    e = exp_q.pop_front();
    n_tests++;
    if (if_rr.out_valid !== 1'b1 || int'(if_rr.out) !== e.idx || if_rr.multi !== e.multi
        || int'(u_rr.r_ptr) !== ptr_rr) begin
      n_fail++;
      $display("FAIL bp_after: valid=%0b out=%0d multi=%0b ptr=%0d want 1 %0d %0b %0d",
               if_rr.out_valid, if_rr.out, if_rr.multi, u_rr.r_ptr, e.idx, e.multi, ptr_rr);
    end
    @(negedge clk);
    n_tests++;
    if (if_rr.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: valid=%0b want 0", if_rr.out_valid);
    end
  endtask

  task automatic test_zero();
    // Continues from backpressure state: empty, ptr non-zero.
    if_rr.in = 8'h00; if_rr.in_valid = 1'b1; if_rr.out_ready = 1'b1;
    @(negedge clk);
    if_rr.in_valid = 1'b0;
    n_tests++;
    if (if_rr.zero_drop !== 1'b1 || if_rr.out_valid !== 1'b0 || int'(u_rr.r_ptr) !== ptr_rr)
    begin
      n_fail++;
      $display("FAIL zero_empty: zd=%0b valid=%0b ptr=%0d want 1 0 %0d",
               if_rr.zero_drop, if_rr.out_valid, u_rr.r_ptr, ptr_rr);
    end
    @(negedge clk);
    n_tests++;
    if (if_rr.zero_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_pulse_len: zd=%0b want 0", if_rr.zero_drop);
    end
    // Zero vector accepted while the held result drains: valid must fall.
    if_rr.in = 8'b1010_0100; if_rr.in_valid = 1'b1;
    push_exp(8'b1010_0100, 8, 1, ptr_rr, ptr_rr);
    @(negedge clk);
    e = exp_q.pop_front();
    n_tests++;
    if (if_rr.out_valid !== 1'b1 || int'(if_rr.out) !== e.idx) begin
      n_fail++;
      $display("FAIL zero_pre: valid=%0b out=%0d want 1 %0d", if_rr.out_valid, if_rr.out, e.idx);
    end
    if_rr.in = 8'h00;
    @(negedge clk);
    if_rr.in_valid = 1'b0;
    n_tests++;
    if (if_rr.zero_drop !== 1'b1 || if_rr.out_valid !== 1'b0 || int'(u_rr.r_ptr) !== ptr_rr)
    begin
      n_fail++;
      $display("FAIL zero_drain: zd=%0b valid=%0b ptr=%0d want 1 0 %0d",
               if_rr.zero_drop, if_rr.out_valid, u_rr.r_ptr, ptr_rr);
    end
    @(negedge clk);
  endtask

  task automatic test_width5();
    do_reset();
    if_w5.enable = 1'b1; if_w5.out_ready = 1'b1;
    if_w5.in = 5'b10001; if_w5.in_valid = 1'b1;
    push_exp(8'b0001_0001, 5, 1, ptr_w5, ptr_w5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) if_w5.in_valid = 1'b0;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL w5_queue: got empty want entry");
      end else begin
        e = exp_q.pop_front();
        if (if_w5.out_valid !== 1'b1 || int'(if_w5.out) !== e.idx
            || {3'b000, if_w5.out_onehot} !== e.oh || if_w5.multi !== e.multi) begin
          n_fail++;
          $display("FAIL w5_%0d: valid=%0b out=%0d oh=%b multi=%0b want 1 %0d %b %0b", i,
                   if_w5.out_valid, if_w5.out, if_w5.out_onehot, if_w5.multi,
                   e.idx, e.oh, e.multi);
        end
      end
      n_tests++;
      if (int'(u_w5.r_ptr) !== ptr_w5) begin
        n_fail++;
        $display("FAIL w5_ptr_%0d: got %0d want %0d", i, u_w5.r_ptr, ptr_w5);
      end
      if (i < 3) push_exp(8'b0001_0001, 5, 1, ptr_w5, ptr_w5);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_enable();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_zero();
    test_width5();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_priority_encoder.md
Name: rr_priority_encoder

Overview:
- Registered successor to the combinational one-hot encoder, with configurable width.
- Accepts arbitrary (not necessarily one-hot) request vectors and selects one set bit by fixed priority or round-robin priority.
- Returns the winner as a binary index plus a one-hot grant, through a valid/ready handshake with one output register stage.
- Sits between request sources and the consumers that need one selected index per transfer.

Parameters:
- WIDTH, 8: number of request bits; legal range is 2 or more.
- RR_MODE, 0: 0 selects fixed priority (lowest index wins); 1 selects round-robin priority from a rotating pointer.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  block enable; when low, no new input is accepted.
- in  input  WIDTH  request vector.
- in_valid  input  1  `in` is presented.
- in_ready  output  1  the block can accept `in` this cycle.
- out  output  $clog2(WIDTH)  binary index of the granted bit.
- out_onehot  output  WIDTH  one-hot grant; equals 1 << out.
- out_valid  output  1  `out` and `out_onehot` hold a result.
- out_ready  input  1  the consumer takes the result this cycle.
- multi  output  1  registered with `out`; set when the source vector had 2 or more bits set.
- zero_drop  output  1  one-cycle pulse: a zero vector was accepted and discarded.

Behaviour:
- Reset:
  - Applies at the clk edge while `reset`=1 and overrides all other activity, including mid-transfer.
  - Clears `out`, `out_onehot`, `out_valid`, `multi`, `zero_drop` and the round-robin pointer `ptr` to 0.
  - Any held result is lost.
- Ready: `in_ready` = `enable` & (!`out_valid` | `out_ready`). It is combinational and has no dependency on `in_valid`.
- Accept: occurs when `in_valid` & `in_ready`.
  - With `in` nonzero, the result registers at the next edge and `out_valid`=1. Latency is 1 cycle.
  - With `in` zero, the input is consumed, no result is produced, and `zero_drop`=1 for the following cycle only.
  - In that zero case, `out_valid` falls if the held result drained in the same cycle.
- Hold: while `out_valid` & !`out_ready`, `out`, `out_onehot` and `multi` are stable and `in_ready`=0.
- Drain: `out_valid` & `out_ready` with no new accept gives `out_valid`=0 at the next edge.
  - Drain and accept in the same cycle replaces the result back-to-back, with `out_valid` staying 1 and full throughput of one per cycle.
- Enable low:
  - `in_ready`=0 and nothing is accepted.
  - A held result stays valid and can still drain.
  - `ptr` is frozen.
- Fixed mode (RR_MODE=0): winner is the lowest set index. `ptr` is unused and stays 0.
- Round-robin mode (RR_MODE=1):
  - Winner is the first set bit searching upward from `ptr`, wrapping from WIDTH-1 to 0.
  - On each nonzero accept, `ptr` becomes (winner+1) mod WIDTH.
  - A zero accept leaves `ptr` unchanged.
- Index width: `out` is $clog2(WIDTH) bits. For non-power-of-2 WIDTH, the wrap compares against WIDTH-1 explicitly and never against 2^n-1.
- `multi` is computed from the accepted vector (popcount of 2 or more), independent of mode.

Test Plan:
- Reset and enable:
  - Assert `reset` mid-hold with `out_valid`=1 and `out`=5. Next edge: all outputs are 0 and `ptr`=0.
  - With `enable`=0, `in`=8'b1000_0000 and `in_valid`=1: `in_ready`=0 and `out_valid` stays 0.
  - Raise `enable`: one cycle later `out`=7, `out_onehot`=8'b1000_0000, `multi`=0.
- Fixed priority:
  - RR_MODE=0, `out_ready`=1, `in`=8'b1010_0100 applied on 3 consecutive cycles.
  - Each result is `out`=2 with `multi`=1, and `out_valid` is continuous.
- Round-robin:
  - RR_MODE=1, `in`=8'b1010_0100 held, `out_ready`=1.
  - Outputs are 2, 5, 7, 2 on successive cycles, with `ptr` stepping 3, 6, 0, 3.
- Backpressure:
  - With `out_ready`=0 after the first result `out`=2: `in_ready`=0 and `out` holds 2 for 4 cycles while `in` changes to 8'b0000_0001.
  - `ptr` stays 3.
  - Release `out_ready`: that cycle drains 2 and accepts `in`; next cycle `out`=0.
- Zero input:
  - `in`=0 with `in_valid`=1 while empty: `zero_drop` pulses 1 cycle, `out_valid` stays 0, `ptr` is unchanged.
- Width corner:
  - WIDTH=5, RR_MODE=1, `in`=5'b10001 held.
  - Outputs alternate 0, 4, 0, 4 and `ptr` wraps 4→0 correctly.
